vga_rect_fill_master: RTL and testbench

//  IO-bus initiator that fills a clipped rectangle of the 320x240, 8-bpp VGA framebuffer with one colour.

---
 rtl/vga_rect_fill_master.sv | 176 +++++++++++++++++
 tb/tb_vga_rect_fill_master.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_rect_fill_master.sv
// IO-bus master that fills a clipped rectangle of the 8-bpp VGA framebuffer with one colour,
// one pixel per accepted write, arbitrating for the bus through oReq/iGrant.
module vga_rect_fill_master #(
    parameter logic [31:0] BASE_ADDR = 32'hFF000000,
    parameter int unsigned H_RES     = 320,
    parameter int unsigned V_RES     = 240
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iStart,
    input  logic        iAbort,
    input  logic [8:0]  iX0,
    input  logic [7:0]  iY0,
    input  logic [8:0]  iW,
    input  logic [7:0]  iH,
    input  logic [7:0]  iColor,
    output logic        oBusy,
    output logic        oDone,
    output logic        oReq,
    input  logic        iGrant,
    input  logic        iReady,
    output logic        wReadEnable,
    output logic        wWriteEnable,
    output logic [3:0]  wByteEnable,
    output logic [31:0] wAddress,
    output logic [31:0] wWriteData
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ARB,
        S_WR,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [8:0]  x0_q, x0_d;
    logic [7:0]  y0_q, y0_d;
    logic [8:0]  w_q, w_d;
    logic [7:0]  h_q, h_d;
    logic [7:0]  color_q, color_d;
    logic [8:0]  col_q, col_d;
    logic [7:0]  row_q, row_d;
    logic [31:0] row_base_q, row_base_d;

    logic [9:0]  x_room;
    logic [8:0]  y_room;
    logic [8:0]  w_clip;
    logic [7:0]  h_clip;
    logic        degenerate;
    logic [31:0] pix_addr;
    logic        last_col;
    logic        last_row;

    // Clipping: x_room/y_room are only meaningful when the origin is on screen,
    // which the degenerate test covers before they are used.
    always_comb begin
        x_room     = 10'(H_RES) - {1'b0, iX0};
        y_room     = 9'(V_RES) - {1'b0, iY0};
        w_clip     = ({1'b0, iW} < x_room) ? iW : x_room[8:0];
        h_clip     = ({1'b0, iH} < y_room) ? iH : y_room[7:0];
        degenerate = (32'(iX0) >= H_RES) || (32'(iY0) >= V_RES) ||
                     (iW == '0) || (iH == '0);
    end

    assign pix_addr = row_base_q + 32'(x0_q) + 32'(col_q);
    assign last_col = (col_q == w_q - 9'd1);
    assign last_row = (row_q == h_q - 8'd1);

    always_comb begin
        state_d      = state_q;
        x0_d         = x0_q;
        y0_d         = y0_q;
        w_d          = w_q;
        h_d          = h_q;
        color_d      = color_q;
        col_d        = col_q;
        row_d        = row_q;
        row_base_d   = row_base_q;
        oDone        = 1'b0;
        oReq         = 1'b0;
        wWriteEnable = 1'b0;
        wByteEnable  = '0;
        wAddress     = '0;
        wWriteData   = '0;

        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    x0_d    = iX0;
                    y0_d    = iY0;
                    w_d     = w_clip;
                    h_d     = h_clip;
                    color_d = iColor;
                    state_d = degenerate ? S_DONE : S_SETUP;
                end
            end
            S_SETUP: begin
                row_base_d = BASE_ADDR + 32'(y0_q) * 32'(H_RES);
                col_d      = '0;
                row_d      = '0;
                state_d    = S_ARB;
            end
            S_ARB: begin
                oReq        = 1'b1;
                wAddress    = pix_addr;
                wByteEnable = 4'b0001 << pix_addr[1:0];
                wWriteData  = {4{color_q}};
                if (iGrant) begin
                    state_d = S_WR;
                end
            end
            S_WR: begin
                oReq         = 1'b1;
                wWriteEnable = iGrant;
                wAddress     = pix_addr;
                wByteEnable  = 4'b0001 << pix_addr[1:0];
                wWriteData   = {4{color_q}};
                if (!iGrant) begin
                    state_d = S_ARB;
                end else if (iReady) begin
                    if (last_col) begin
                        col_d = '0;
                        if (last_row) begin
                            state_d = S_DONE;
                        end else begin
                            row_d      = row_q + 8'd1;
                            row_base_d = row_base_q + 32'(H_RES);
                        end
                    end else begin
                        col_d = col_q + 9'd1;
                    end
                end
            end
            S_DONE: begin
                oDone   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides any progress; a write accepted this cycle has already happened.
        if (iAbort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    assign oBusy       = (state_q != S_IDLE);
    assign wReadEnable = 1'b0;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q    <= S_IDLE;
            x0_q       <= '0;
            y0_q       <= '0;
            w_q        <= '0;
            h_q        <= '0;
            color_q    <= '0;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
        end else begin
            state_q    <= state_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            w_q        <= w_d;
            h_q        <= h_d;
            color_q    <= color_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
        end
    end

endmodule

// File: tb/tb_vga_rect_fill_master.sv
// Directed, table-driven bench for vga_rect_fill_master: fills, clipping, degenerate commands,
// wait states, grant loss, abort, start-while-busy and asynchronous reset mid-fill.
module tb_vga_rect_fill_master;

    logic        iCLK = 1'b0;
    logic        iRST_N = 1'b0;
    logic        iStart = 1'b0;
    logic        iAbort = 1'b0;
    logic [8:0]  iX0 = '0;
    logic [7:0]  iY0 = '0;
    logic [8:0]  iW = '0;
    logic [7:0]  iH = '0;
    logic [7:0]  iColor = '0;
    logic        iGrant = 1'b1;
    logic        iReady = 1'b1;
    logic        oBusy, oDone, oReq;
    logic        wReadEnable, wWriteEnable;
    logic [3:0]  wByteEnable;
    logic [31:0] wAddress, wWriteData;

    vga_rect_fill_master #(
        .BASE_ADDR(32'hFF000000),
        .H_RES    (320),
        .V_RES    (240)
    ) dut (
        .iCLK        (iCLK),
        .iRST_N      (iRST_N),
        .iStart      (iStart),
        .iAbort      (iAbort),
        .iX0         (iX0),
        .iY0         (iY0),
        .iW          (iW),
        .iH          (iH),
        .iColor      (iColor),
        .oBusy       (oBusy),
        .oDone       (oDone),
        .oReq        (oReq),
        .iGrant      (iGrant),
        .iReady      (iReady),
        .wReadEnable (wReadEnable),
        .wWriteEnable(wWriteEnable),
        .wByteEnable (wByteEnable),
        .wAddress    (wAddress),
        .wWriteData  (wWriteData)
    );

    always #5 iCLK = ~iCLK;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Write monitor
    logic [31:0] wr_q[$];
    logic [31:0] stall_q[$];
    int          n_acc = 0;
    int          gnt_viol = 0;
    logic [7:0]  exp_color = '0;

    always @(negedge iCLK) begin
        if (iRST_N) begin
            if (wWriteEnable && iReady) begin
                logic [3:0] be_exp;
                be_exp = 4'b0001;
                be_exp = be_exp << wAddress[1:0];
                wr_q.push_back(wAddress);
                n_acc++;
                check("wdata", wWriteData, {4{exp_color}});
                check("byte_en", 32'(wByteEnable), 32'(be_exp));
                check("rd_en", 32'(wReadEnable), 32'd0);
            end
            if (wWriteEnable && !iReady) stall_q.push_back(wAddress);
            if (wWriteEnable && !iGrant) gnt_viol++;
        end
    end

    // Handshake disturbance driver
    int mode = 0;
    int stall_n = 0;
    int drop_n = 0;

    always @(posedge iCLK) begin
        #2;
        case (mode)
            1: if (n_acc == 1 && stall_n < 3) begin iReady = 1'b0; stall_n++; end
               else iReady = 1'b1;
            2: if (n_acc == 2 && drop_n < 4) begin iGrant = 1'b0; drop_n++; end
               else iGrant = 1'b1;
            3: if (n_acc == 1 && drop_n == 0) begin
                   iStart = 1'b1; iX0 = 9'd100; iY0 = 8'd50; iW = 9'd5; iH = 8'd5;
                   iColor = 8'hFF; drop_n = 1;
               end else if (drop_n == 1) begin
                   iStart = 1'b0; drop_n = 2;
               end
            default: ;
        endcase
    end

    task automatic start_cmd(input logic [8:0] x0, input logic [7:0] y0, input logic [8:0] w,
                             input logic [7:0] h, input logic [7:0] c);
        @(posedge iCLK); #1;
        iX0 = x0; iY0 = y0; iW = w; iH = h; iColor = c; exp_color = c;
        wr_q.delete(); stall_q.delete(); n_acc = 0; gnt_viol = 0;
        iStart = 1'b1;
        @(posedge iCLK); #1;
        iStart = 1'b0;
    endtask

    // Negedge count after the sampling edge until oDone / first oReq (-1 if never)
    task automatic wait_done(output int lat, output int req_lat);
        lat = -1; req_lat = -1;
        for (int n = 1; n <= 3000; n++) begin
            @(negedge iCLK);
            if (oReq && req_lat < 0) req_lat = n;
            if (oDone) begin lat = n; break; end
        end
    endtask

    task automatic check_model(input int x0, input int y0, input int w, input int h);
        int wc, hc, idx;
        logic [31:0] ea;
        wc = (w < 320 - x0) ? w : 320 - x0;
        hc = (h < 240 - y0) ? h : 240 - y0;
        if (x0 >= 320 || y0 >= 240 || w == 0 || h == 0) begin wc = 0; hc = 0; end
        check("wr_count", wr_q.size(), wc * hc);
        idx = 0;
        for (int r = 0; r < hc; r++) begin
            for (int c = 0; c < wc; c++) begin
                ea = 32'hFF000000 + (y0 + r) * 320 + x0 + c;
                if (idx < wr_q.size()) check("wr_addr", wr_q[idx], ea);
                idx++;
            end
        end
    endtask

    typedef struct {
        logic [8:0]  x0;
        logic [7:0]  y0;
        logic [8:0]  w;
        logic [7:0]  h;
        logic [7:0]  c;
        int          nwr;
        logic [31:0] first;
        logic [31:0] last;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int lat, req_lat, ndone;

        tbl[0] = '{9'd2,   8'd1,   9'd3,   8'd2, 8'hA5,   6, 32'hFF000142, 32'hFF000284};
        tbl[1] = '{9'd318, 8'd239, 9'd10,  8'd5, 8'h3C,   2, 32'hFF012BFE, 32'hFF012BFF};
        tbl[2] = '{9'd0,   8'd0,   9'd4,   8'd1, 8'h11,   4, 32'hFF000000, 32'hFF000003};
        tbl[3] = '{9'd300, 8'd10,  9'd100, 8'd3, 8'h7E,  60, 32'hFF000DAC, 32'hFF00103F};
        tbl[4] = '{9'd5,   8'd5,   9'd0,   8'd4, 8'h22,   0, 32'h0,        32'h0};
        tbl[5] = '{9'd320, 8'd0,   9'd4,   8'd4, 8'h33,   0, 32'h0,        32'h0};
        tbl[6] = '{9'd0,   8'd240, 9'd4,   8'd4, 8'h44,   0, 32'h0,        32'h0};
        tbl[7] = '{9'd7,   8'd3,   9'd2,   8'd0, 8'h55,   0, 32'h0,        32'h0};
        tbl[8] = '{9'd319, 8'd0,   9'd1,   8'd3, 8'h66,   3, 32'hFF00013F, 32'hFF0003BF};
        tbl[9] = '{9'd0,   8'd238, 9'd320, 8'd2, 8'h99, 640, 32'hFF012980, 32'hFF012BFF};

        // Reset state
        #12;
        check("rst_busy", 32'(oBusy), 0);
        check("rst_done", 32'(oDone), 0);
        check("rst_req", 32'(oReq), 0);
        check("rst_we", 32'(wWriteEnable), 0);
        check("rst_addr", wAddress, 0);
        check("rst_data", wWriteData, 0);
        check("rst_be", 32'(wByteEnable), 0);
        @(posedge iCLK); #1;
        iRST_N = 1'b1;

        // Table-driven fills
        for (int i = 0; i < 10; i++) begin
            start_cmd(tbl[i].x0, tbl[i].y0, tbl[i].w, tbl[i].h, tbl[i].c);
            wait_done(lat, req_lat);
            check($sformatf("v%0d_nwr", i), wr_q.size(), tbl[i].nwr);
            if (tbl[i].nwr > 0) begin
                check($sformatf("v%0d_first", i), wr_q[0], tbl[i].first);
                check($sformatf("v%0d_last", i), wr_q[wr_q.size()-1], tbl[i].last);
            end
            check_model(tbl[i].x0, tbl[i].y0, tbl[i].w, tbl[i].h);
            check($sformatf("v%0d_done_lat", i), lat, (tbl[i].nwr > 0) ? tbl[i].nwr + 3 : 1);
            check($sformatf("v%0d_req_lat", i), req_lat, (tbl[i].nwr > 0) ? 2 : -1);
            @(negedge iCLK);
            check($sformatf("v%0d_done_pulse", i), 32'(oDone), 0);
            check($sformatf("v%0d_idle", i), 32'(oBusy), 0);
        end

        // Wait states on pixel 2
        mode = 1; stall_n = 0;
        start_cmd(9'd2, 8'd1, 9'd3, 8'd2, 8'hA5);
        wait_done(lat, req_lat);
        check_model(2, 1, 3, 2);
        check("stall_cycles", stall_q.size(), 3);
        foreach (stall_q[k]) check("stall_addr", stall_q[k], 32'hFF000143);
        check("stall_done_lat", lat, 12);

        // Grant loss mid-row
        mode = 2; drop_n = 0; iReady = 1'b1;
        start_cmd(9'd2, 8'd1, 9'd3, 8'd2, 8'hA5);
        wait_done(lat, req_lat);
        check_model(2, 1, 3, 2);
        check("gnt_we_viol", gnt_viol, 0);
        check("gnt_done_lat", lat >= 0 ? 32'd1 : 32'd0, 32'd1);
        @(negedge iCLK);
        check("gnt_idle", 32'(oBusy), 0);

        // Start while busy
        mode = 3; drop_n = 0; iGrant = 1'b1;
        start_cmd(9'd0, 8'd0, 9'd4, 8'd1, 8'h11);
        wait_done(lat, req_lat);
        check_model(0, 0, 4, 1);
        check("busy_start_lat", lat, 7);
        ndone = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge iCLK);
            if (oBusy || oDone) ndone++;
        end
        check("busy_start_quiet", ndone, 0);
        mode = 0;

        // Abort after 2 accepted writes
        start_cmd(9'd2, 8'd1, 9'd3, 8'd2, 8'hA5);
        for (int n = 0; n < 50 && n_acc < 2; n++) begin @(negedge iCLK); #1; end
        check("abort_reach", n_acc, 2);
        ndone = 0;
        @(posedge iCLK); #1;
        iAbort = 1'b1;
        @(negedge iCLK);
        if (oDone) ndone++;
        @(posedge iCLK); #1;
        iAbort = 1'b0;
        @(negedge iCLK);
        check("abort_busy", 32'(oBusy), 0);
        check("abort_req", 32'(oReq), 0);
        check("abort_we", 32'(wWriteEnable), 0);
        check("abort_addr", wAddress, 0);
        for (int n = 0; n < 4; n++) begin
            if (oDone) ndone++;
            @(negedge iCLK);
        end
        check("abort_no_done", ndone, 0);
        check("abort_nwr", wr_q.size(), 3);
        if (wr_q.size() == 3) check("abort_last_wr", wr_q[2], 32'hFF000144);

        // Asynchronous reset mid-fill, then a normal fill
        start_cmd(9'd2, 8'd1, 9'd3, 8'd2, 8'hA5);
        for (int n = 0; n < 50 && n_acc < 2; n++) begin @(negedge iCLK); #1; end
        check("rst_mid_reach", n_acc, 2);
        #1 iRST_N = 1'b0;
        #1;
        check("rst_mid_busy", 32'(oBusy), 0);
        check("rst_mid_req", 32'(oReq), 0);
        check("rst_mid_we", 32'(wWriteEnable), 0);
        check("rst_mid_addr", wAddress, 0);
        check("rst_mid_data", wWriteData, 0);
        check("rst_mid_be", 32'(wByteEnable), 0);
        @(posedge iCLK); #1;
        iRST_N = 1'b1;
        start_cmd(9'd2, 8'd1, 9'd3, 8'd2, 8'hA5);
        wait_done(lat, req_lat);
        check_model(2, 1, 3, 2);
        check("post_rst_lat", lat, 9);
        check("post_rst_req_lat", req_lat, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_total);
        $fatal(1);
    end

endmodule
